// File: rtl/ara_axi_w_responder_pkg.sv
// Shared types and constants for the Ara AXI write-channel responder.
package ara_axi_w_responder_pkg;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  // Entry fields are sized for the widest supported ID and delay.
  localparam int unsigned MaxIdWidth = 16;
  localparam int unsigned CntWidth   = 16;

  typedef struct packed {
    logic [MaxIdWidth-1:0] id;
    logic [1:0]            resp;
    logic [CntWidth-1:0]   countdown;
  } b_entry_t;

  typedef enum logic {
    IDLE,
    DATA
  } state_e;

endpackage

// File: rtl/ara_axi_w_responder_if.sv
// AW/W/B handshake and serialized byte stream between the VLSU and the responder.
interface ara_axi_w_responder_if #(
  parameter int unsigned AxiDataWidth = 256,
  parameter int unsigned AxiIdWidth   = 5
);
  logic                      aw_valid_i;
  logic                      aw_ready_o;
  logic [AxiIdWidth-1:0]     aw_id_i;
  logic [7:0]                aw_len_i;
  logic                      w_valid_i;
  logic                      w_ready_o;
  logic [AxiDataWidth-1:0]   w_data_i;
  logic [AxiDataWidth/8-1:0] w_strb_i;
  logic                      w_last_i;
  logic                      b_valid_o;
  logic                      b_ready_i;
  logic [AxiIdWidth-1:0]     b_id_o;
  logic [1:0]                b_resp_o;
  logic                      byte_valid_o;
  logic [7:0]                byte_data_o;

  modport slave (
    input  aw_valid_i, aw_id_i, aw_len_i, w_valid_i, w_data_i, w_strb_i, w_last_i, b_ready_i,
    output aw_ready_o, w_ready_o, b_valid_o, b_id_o, b_resp_o, byte_valid_o, byte_data_o
  );

  modport master (
    output aw_valid_i, aw_id_i, aw_len_i, w_valid_i, w_data_i, w_strb_i, w_last_i, b_ready_i,
    input  aw_ready_o, w_ready_o, b_valid_o, b_id_o, b_resp_o, byte_valid_o, byte_data_o
  );
endinterface

// File: rtl/ara_strb_serializer.sv
// Emits the strobed bytes of one W beat, lowest lane first, one byte per cycle.
module ara_strb_serializer #(
  parameter int unsigned DataWidth = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   load_i,
  input  logic [DataWidth-1:0]   data_i,
  input  logic [DataWidth/8-1:0] strb_i,
  output logic                   empty_o,
  output logic                   drain_o,
  output logic                   byte_valid_o,
  output logic [7:0]             byte_data_o
);
  localparam int unsigned NrLanes = DataWidth / 8;
  localparam int unsigned LaneW   = (NrLanes > 1) ? $clog2(NrLanes) : 1;

  logic [DataWidth-1:0] data_q;
  logic [NrLanes-1:0]   mask_q;
  logic [NrLanes-1:0]   mask_clr;
  logic [LaneW-1:0]     lane_sel;

  always_comb begin
    lane_sel = '0;
    for (int unsigned i = 0; i < NrLanes; i++) begin
      if (mask_q[NrLanes-1-i]) lane_sel = LaneW'(NrLanes-1-i);
    end
  end

  // Clearing the lowest set bit; drain_o flags that this cycle emits the final byte.
  assign mask_clr     = mask_q & (mask_q - NrLanes'(1));
  assign empty_o      = (mask_q == '0);
  assign drain_o      = (mask_clr == '0);
  assign byte_valid_o = !empty_o;
  assign byte_data_o  = empty_o ? '0 : data_q[{lane_sel, 3'b000} +: 8];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
      mask_q <= '0;
    end else if (load_i) begin
      data_q <= data_i;
      mask_q <= strb_i;
    end else begin
      mask_q <= mask_clr;
    end
  end

endmodule

// File: rtl/ara_axi_w_responder.sv
// AXI write-channel responder: accepts AW/W bursts, serializes strobed bytes, returns delayed in-order B.
module ara_axi_w_responder
  import ara_axi_w_responder_pkg::*;
#(
  parameter int unsigned AxiDataWidth   = 256,
  parameter int unsigned AxiIdWidth     = 5,
  parameter int unsigned RespDelay      = 4,
  parameter int unsigned MaxOutstanding = 4
) (
  input logic                  clk_i,
  input logic                  rst_i,
  ara_axi_w_responder_if.slave axi
);
  localparam int unsigned PtrW = $clog2(MaxOutstanding);

  state_e state_q, state_d;

  logic [AxiIdWidth-1:0] id_q;
  logic [7:0]            len_q;
  logic [7:0]            beat_cnt_q;
  logic                  err_q;
  logic                  last_seen_q;
  logic                  started_q;
  logic                  aw_hs, w_hs, push, pop;
  logic                  ser_empty, ser_drain;

  b_entry_t              queue_q [MaxOutstanding];
  b_entry_t              head;
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]         count_q;
  logic                  unused_id_hi;

  ara_strb_serializer #(
    .DataWidth (AxiDataWidth)
  ) i_serializer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .load_i       (w_hs),
    .data_i       (axi.w_data_i),
    .strb_i       (axi.w_strb_i),
    .empty_o      (ser_empty),
    .drain_o      (ser_drain),
    .byte_valid_o (axi.byte_valid_o),
    .byte_data_o  (axi.byte_data_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // The burst closes on the cycle its final byte leaves, not when the last beat arrives.
  always_comb begin
    state_d        = state_q;
    axi.aw_ready_o = 1'b0;
    axi.w_ready_o  = 1'b0;
    push           = 1'b0;
    unique case (state_q)
      IDLE: begin
        axi.aw_ready_o = started_q && (count_q < (PtrW+1)'(MaxOutstanding));
        if (axi.aw_valid_i && axi.aw_ready_o) state_d = DATA;
      end
      DATA: begin
        axi.w_ready_o = ser_empty && !last_seen_q;
        if (last_seen_q && ser_drain) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  assign aw_hs = axi.aw_valid_i & axi.aw_ready_o;
  assign w_hs  = axi.w_valid_i & axi.w_ready_o;

  // Error is sticky: a last beat at the wrong index, or any non-last beat at index len.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      started_q   <= 1'b0;
      id_q        <= '0;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      err_q       <= 1'b0;
      last_seen_q <= 1'b0;
    end else begin
      started_q <= 1'b1;
      if (aw_hs) begin
        id_q        <= axi.aw_id_i;
        len_q       <= axi.aw_len_i;
        beat_cnt_q  <= '0;
        err_q       <= 1'b0;
        last_seen_q <= 1'b0;
      end else if (w_hs) begin
        if (beat_cnt_q != 8'hff) beat_cnt_q <= beat_cnt_q + 8'd1;
        if (axi.w_last_i ? (beat_cnt_q != len_q) : (beat_cnt_q == len_q)) err_q <= 1'b1;
        if (axi.w_last_i) last_seen_q <= 1'b1;
      end else if (push) begin
        last_seen_q <= 1'b0;
      end
    end
  end

  assign head            = queue_q[rd_ptr_q];
  assign pop             = axi.b_valid_o & axi.b_ready_i;
  assign axi.b_valid_o   = (count_q != '0) && (head.countdown == '0);
  assign axi.b_id_o      = head.id[AxiIdWidth-1:0];
  assign axi.b_resp_o    = head.resp;
  assign unused_id_hi    = |(head.id >> AxiIdWidth);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < MaxOutstanding; i++) queue_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < MaxOutstanding; i++) begin
        if (queue_q[i].countdown != '0) queue_q[i].countdown <= queue_q[i].countdown - CntWidth'(1);
      end
      if (push) begin
        queue_q[wr_ptr_q] <= '{id:        MaxIdWidth'(id_q),
                               resp:      err_q ? RespSlvErr : RespOkay,
                               countdown: CntWidth'(RespDelay)};
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_ara_axi_w_responder.sv
// Directed and randomized bench for ara_axi_w_responder with a byte/response queue model.
module tb_ara_axi_w_responder;
  localparam int unsigned DW = 256;
  localparam int unsigned IW = 5;
  localparam int unsigned RD = 4;
  localparam int unsigned MO = 4;
  localparam int unsigned NL = DW / 8;

  typedef struct {
    logic [IW-1:0] id;
    logic [1:0]    resp;
  } b_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   b_mode = 1;

  logic [7:0]    exp_bytes[$];
  b_exp_t        exp_b[$];
  logic [DW-1:0] beat_data [16];
  logic [NL-1:0] beat_strb [16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ara_axi_w_responder_if #(.AxiDataWidth(DW), .AxiIdWidth(IW)) axi_if ();

  ara_axi_w_responder #(
    .AxiDataWidth   (DW),
    .AxiIdWidth     (IW),
    .RespDelay      (RD),
    .MaxOutstanding (MO)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .axi   (axi_if)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // 0: hold low, 1: hold high, otherwise random each cycle
  always begin
    @(posedge clk);
    #1;
    case (b_mode)
      0:       axi_if.b_ready_i = 1'b0;
      1:       axi_if.b_ready_i = 1'b1;
      default: axi_if.b_ready_i = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (!rst && axi_if.byte_valid_o === 1'b1) begin
      if (exp_bytes.size() == 0) chk("byte_unexpected", 1, 0);
      else chk("byte_data", axi_if.byte_data_o, exp_bytes.pop_front());
    end
  end

  logic          stall = 1'b0;
  logic [IW-1:0] stall_id;
  logic [1:0]    stall_resp;
  always @(negedge clk) begin : b_mon
    b_exp_t e;
    if (rst) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("b_hold_valid", axi_if.b_valid_o, 1);
        chk("b_hold_id", axi_if.b_id_o, stall_id);
        chk("b_hold_resp", axi_if.b_resp_o, stall_resp);
      end
      if (axi_if.b_valid_o === 1'b1 && axi_if.b_ready_i === 1'b1) begin
        if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
        else begin
          e = exp_b.pop_front();
          chk("b_id", axi_if.b_id_o, e.id);
          chk("b_resp", axi_if.b_resp_o, e.resp);
        end
      end
      stall      = (axi_if.b_valid_o === 1'b1) && (axi_if.b_ready_i !== 1'b1);
      stall_id   = axi_if.b_id_o;
      stall_resp = axi_if.b_resp_o;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // All handshake tasks start and end just after a rising edge.
  task automatic do_aw(input logic [IW-1:0] id, input logic [7:0] len);
    bit ok = 0;
    axi_if.aw_valid_i = 1'b1;
    axi_if.aw_id_i    = id;
    axi_if.aw_len_i   = len;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = (axi_if.aw_ready_o === 1'b1);
      @(posedge clk);
      #1;
    end
    axi_if.aw_valid_i = 1'b0;
    chk("aw_handshake", ok, 1);
  endtask

  task automatic do_w(input logic [DW-1:0] data, input logic [NL-1:0] strb, input bit last, output int hs);
    bit ok = 0;
    hs = -1;
    axi_if.w_valid_i = 1'b1;
    axi_if.w_data_i  = data;
    axi_if.w_strb_i  = strb;
    axi_if.w_last_i  = last;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = (axi_if.w_ready_o === 1'b1);
      hs = cyc;
      @(posedge clk);
      #1;
    end
    axi_if.w_valid_i = 1'b0;
    axi_if.w_last_i  = 1'b0;
    chk("w_handshake", ok, 1);
  endtask

  task automatic expect_beat(input int b);
    for (int k = 0; k < int'(NL); k++) if (beat_strb[b][k]) exp_bytes.push_back(beat_data[b][8*k +: 8]);
  endtask

  task automatic expect_b(input logic [IW-1:0] id, input logic [7:0] len, input int nbeats);
    b_exp_t e;
    e.id   = id;
    e.resp = (nbeats == int'(len) + 1) ? 2'b00 : 2'b10;
    exp_b.push_back(e);
  endtask

  task automatic send_burst(input logic [IW-1:0] id, input logic [7:0] len, input int nbeats,
                            output int hs_first, output int hs_last);
    int hs;
    hs_first = -1;
    hs_last  = -1;
    expect_b(id, len, nbeats);
    do_aw(id, len);
    for (int b = 0; b < nbeats; b++) begin
      expect_beat(b);
      do_w(beat_data[b], beat_strb[b], b == nbeats - 1, hs);
      if (b == 0) hs_first = hs;
      hs_last = hs;
    end
  endtask

  task automatic rand_beat(input int b, input int kind);
    for (int w = 0; w < int'(DW / 32); w++) beat_data[b][32*w +: 32] = $urandom;
    case (kind)
      0:       beat_strb[b] = '0;
      1:       beat_strb[b] = '1;
      2:       beat_strb[b] = NL'($urandom);
      default: beat_strb[b] = NL'($urandom & $urandom & $urandom);
    endcase
  endtask

  task automatic drain(input string tag);
    bit ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(posedge clk);
      #1;
      ok = (exp_b.size() == 0) && (exp_bytes.size() == 0);
    end
    chk(tag, ok, 1);
  endtask

  initial begin
    int f, l, h0, h1, seen, nb;
    logic [7:0] len;
    axi_if.aw_valid_i = 1'b0;
    axi_if.aw_id_i    = '0;
    axi_if.aw_len_i   = '0;
    axi_if.w_valid_i  = 1'b0;
    axi_if.w_data_i   = '0;
    axi_if.w_strb_i   = '0;
    axi_if.w_last_i   = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_aw_ready", axi_if.aw_ready_o, 0);
    chk("rst_w_ready", axi_if.w_ready_o, 0);
    chk("rst_b_valid", axi_if.b_valid_o, 0);
    chk("rst_b_id", axi_if.b_id_o, 0);
    chk("rst_b_resp", axi_if.b_resp_o, 0);
    chk("rst_byte_valid", axi_if.byte_valid_o, 0);
    chk("rst_byte_data", axi_if.byte_data_o, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single beat, lanes 0 and 2
    rand_beat(0, 2);
    beat_data[0][7:0]   = 8'hAA;
    beat_data[0][23:16] = 8'hBB;
    beat_strb[0]        = NL'(32'h0000_0005);
    send_burst(5'd3, 8'd0, 1, f, l);
    @(negedge clk);
    chk("t1_byte0_valid", axi_if.byte_valid_o, 1);
    chk("t1_byte0", axi_if.byte_data_o, 8'hAA);
    @(negedge clk);
    chk("t1_byte1_valid", axi_if.byte_valid_o, 1);
    chk("t1_byte1", axi_if.byte_data_o, 8'hBB);
    repeat (RD) begin
      @(negedge clk);
      chk("t1_b_early", axi_if.b_valid_o, 0);
      chk("t1_no_extra_byte", axi_if.byte_valid_o, 0);
    end
    @(negedge clk);
    chk("t1_b_valid", axi_if.b_valid_o, 1);
    chk("t1_b_id", axi_if.b_id_o, 3);
    chk("t1_b_resp", axi_if.b_resp_o, 0);
    drain("t1_drain");

    // Zero strobes: one beat per cycle, no bytes
    for (int b = 0; b < 4; b++) rand_beat(b, 0);
    send_burst(5'd5, 8'd3, 4, f, l);
    chk("t2_beat_rate", l - f, 3);
    drain("t2_drain");

    // Length mismatches
    for (int b = 0; b < 3; b++) rand_beat(b, 3);
    send_burst(5'd7, 8'd3, 3, f, l);
    for (int b = 0; b < 3; b++) rand_beat(b, 3);
    send_burst(5'd9, 8'd0, 3, f, l);
    drain("t3_drain");

    // Queue full with B held off
    b_mode = 0;
    for (int i = 0; i < int'(MO); i++) begin
      rand_beat(0, 3);
      beat_strb[0][0] = 1'b1;
      send_burst(IW'(10 + i), 8'd0, 1, f, l);
    end
    repeat (40) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("t4_aw_ready_full", axi_if.aw_ready_o, 0);
    chk("t4_b_waiting", axi_if.b_valid_o, 1);
    b_mode = 1;
    @(negedge clk);
    chk("t4_first_pop", axi_if.b_valid_o & axi_if.b_ready_i, 1);
    chk("t4_aw_ready_at_pop", axi_if.aw_ready_o, 0);
    @(negedge clk);
    chk("t4_aw_ready_after_pop", axi_if.aw_ready_o, 1);
    drain("t4_drain");

    // Full strobe: 32 consecutive bytes, next beat at c+33
    rand_beat(0, 1);
    rand_beat(1, 2);
    expect_b(5'd20, 8'd1, 2);
    do_aw(5'd20, 8'd1);
    expect_beat(0);
    do_w(beat_data[0], beat_strb[0], 1'b0, h0);
    for (int i = 1; i <= int'(NL); i++) begin
      @(negedge clk);
      chk("t5_byte_valid", axi_if.byte_valid_o, 1);
      chk("t5_byte_lane", axi_if.byte_data_o, beat_data[0][8*(i-1) +: 8]);
      if (i == int'(NL)) chk("t5_w_ready_busy", axi_if.w_ready_o, 0);
    end
    @(posedge clk);
    #1;
    expect_beat(1);
    do_w(beat_data[1], beat_strb[1], 1'b1, h1);
    chk("t5_next_beat", h1 - h0, NL + 1);
    drain("t5_drain");

    // Randomized bursts with random B backpressure
    b_mode = 2;
    for (int t = 0; t < 12; t++) begin
      nb  = $urandom_range(1, 4);
      len = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'(nb - 1);
      for (int b = 0; b < nb; b++) rand_beat(b, $urandom_range(0, 3));
      send_burst(IW'($urandom), len, nb, f, l);
    end
    b_mode = 1;
    drain("t6_drain");

    // Reset in the middle of a full-strobe beat
    rand_beat(0, 1);
    expect_b(5'd21, 8'd0, 1);
    do_aw(5'd21, 8'd0);
    expect_beat(0);
    do_w(beat_data[0], beat_strb[0], 1'b1, h0);
    repeat (5) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t7_byte_valid_cleared", axi_if.byte_valid_o, 0);
    chk("t7_w_ready_cleared", axi_if.w_ready_o, 0);
    chk("t7_b_valid_cleared", axi_if.b_valid_o, 0);
    exp_bytes.delete();
    exp_b.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (axi_if.b_valid_o !== 1'b0 || axi_if.byte_valid_o !== 1'b0) seen++;
    end
    chk("t7_no_stale_output", seen, 0);
    @(posedge clk);
    #1;
    rand_beat(0, 2);
    rand_beat(1, 3);
    send_burst(5'd22, 8'd1, 2, f, l);
    drain("t7_drain");

    chk("end_bytes_empty", exp_bytes.size(), 0);
    chk("end_b_empty", exp_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
